// File: rtl/sync_fwft_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fwft_fifo_if
// Description : Write/read handshake bundle for the single-clock FWFT FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fwft_fifo_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             full;
    logic             prog_full;
    logic [WIDTH-1:0] dout;
    logic             rd_en;
    logic             empty;

    modport master (
        output din, wr_en, rd_en,
        input  full, prog_full, dout, empty
    );

    modport slave (
        input  din, wr_en, rd_en,
        output full, prog_full, dout, empty
    );
endinterface
`default_nettype wire

// File: rtl/sync_fwft_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fwft_fifo
// Description : Single-clock first-word-fall-through FIFO; head word is
//               presented on dout whenever empty is low.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fwft_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int PROG_FULL = DEPTH / 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sync_fwft_fifo_if.slave   bus
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = ADDR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fwft_fifo: DEPTH must be a power of two >= 2");
    end
    if (PROG_FULL < 1 || PROG_FULL > DEPTH) begin : g_bad_prog_full
        $fatal(1, "sync_fwft_fifo: PROG_FULL must be in 1..DEPTH");
    end

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_ok;
    logic              w_rd_ok;

    // Flags come only from the registered count, so acceptance never
    // depends combinationally on the opposite request.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_wr_ok = bus.wr_en & ~w_full;
    assign w_rd_ok = bus.rd_en & ~w_empty;

    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.prog_full = (r_count >= CNT_W'(PROG_FULL));
    assign bus.dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_wr_ok && !w_rd_ok) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_rd_ok && !w_wr_ok) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sync_fwft_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fwft_fifo
// Description : Scoreboard bench for sync_fwft_fifo (WIDTH=32, DEPTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fwft_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int PF    = DEPTH / 2;

    logic clk;
    logic rst;
    sync_fwft_fifo_if #(.WIDTH(WIDTH)) bus ();

    sync_fwft_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PROG_FULL(PF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               checks   = 0;
    int               failures = 0;
    logic [WIDTH-1:0] sb[$];
    int               m_cnt    = 0;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_flags(input string tag);
        check_val({tag, ".empty"}, WIDTH'(bus.empty), WIDTH'(m_cnt == 0));
        check_val({tag, ".full"}, WIDTH'(bus.full), WIDTH'(m_cnt == DEPTH));
        check_val({tag, ".prog_full"}, WIDTH'(bus.prog_full), WIDTH'(m_cnt >= PF));
        if (m_cnt > 0) check_val({tag, ".head"}, bus.dout, sb[0]);
    endtask

    // Called at a falling edge; drives one cycle of requests and checks the
    // result at the next falling edge.
    task automatic step(input string tag, input logic wr, input logic [WIDTH-1:0] data,
                        input logic rd);
        logic wr_ok;
        logic rd_ok;
        logic [WIDTH-1:0] exp;
        bus.din   = data;
        bus.wr_en = wr;
        bus.rd_en = rd;
        wr_ok = wr && (m_cnt < DEPTH);
        rd_ok = rd && (m_cnt > 0);
        if (rd_ok) begin
            exp = sb.pop_front();
            check_val({tag, ".rd_data"}, bus.dout, exp);
        end
        if (wr_ok) sb.push_back(data);
        m_cnt = m_cnt + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
        @(posedge clk);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check_flags(tag);
    endtask

    task automatic drain(input string tag);
        while (m_cnt > 0) step(tag, 1'b0, '0, 1'b1);
    endtask

    initial begin
        int words;
        int cyc;
        logic wr;
        logic rd;
        rst       = 1'b1;
        bus.din   = '0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        repeat (2) @(negedge clk);
        check_flags("reset");
        rst = 1'b0;
        @(negedge clk);

        // Idle reads on an empty FIFO
        for (int i = 0; i < 5; i++) step("idle_rd", 1'b0, '0, 1'b1);

        // FWFT latency
        step("fwft_wr", 1'b1, 32'hA5A5_0001, 1'b0);
        check_val("fwft_dout", bus.dout, 32'hA5A5_0001);
        step("fwft_rd", 1'b0, '0, 1'b1);

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, WIDTH'(i), 1'b0);
        step("ovf", 1'b1, 32'hDEAD, 1'b0);
        drain("drain1");

        // Full boundary with simultaneous read+write
        for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, WIDTH'(i + 100), 1'b0);
        step("full_rw", 1'b1, 32'h99, 1'b1);
        check_val("full_rw.cnt15", WIDTH'(bus.full), '0);
        step("refill", 1'b1, 32'h99, 1'b0);
        drain("drain2");

        // Empty boundary with simultaneous read+write, then wrap streaming
        step("empty_rw", 1'b1, 32'h7, 1'b1);
        check_val("empty_rw.dout", bus.dout, 32'h7);
        words = 0;
        cyc   = 0;
        while (words < 40 && cyc < 400) begin
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (m_cnt <= 1) rd = wr;
            if (m_cnt >= 3 && wr) rd = 1'b1;
            step("stream", wr, WIDTH'(32'h1000 + words), rd);
            if (wr) words++;
            cyc++;
        end
        check_val("stream.words", WIDTH'(words), WIDTH'(40));
        drain("drain3");

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, WIDTH'(32'h200 + i), 1'b0);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        m_cnt = 0;
        check_val("arst.empty", WIDTH'(bus.empty), WIDTH'(1));
        check_val("arst.full", WIDTH'(bus.full), '0);
        check_val("arst.prog_full", WIDTH'(bus.prog_full), '0);
        #1 rst = 1'b0;
        @(negedge clk);
        step("post_rst", 1'b1, 32'h55, 1'b0);
        check_val("post_rst.dout", bus.dout, 32'h55);
        drain("drain4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
